// File: rtl/editor_campos_rtc_if.sv
// ---------------------------------------------------------------------------
// editor_campos_rtc_if
// Bus between the RTC field editor and its neighbours. It carries the
// modifier path, the field values and the write handshake.
//   master (editor) drives : dato_e, tipo, s_r, campo0..2, wr_req
//   master (editor) reads  : dato_s, wr_ack
//   slave  (modifier / RTC writer / display) is the mirror image.
// Signals:
//   dato_e  [7:0] BCD value of the selected field, to the modifier
//   tipo    [4:0] one-hot range code of the selected field
//   s_r           1 = add one, 0 = subtract one
//   dato_s  [7:0] BCD result returned by the modifier
//   campo0..2 [7:0] current BCD field values
//   wr_req / wr_ack commit request/acknowledge with the write sequencer
// ---------------------------------------------------------------------------
interface editor_campos_rtc_if;
  logic [7:0] dato_e;
  logic [4:0] tipo;
  logic       s_r;
  logic [7:0] dato_s;
  logic [7:0] campo0;
  logic [7:0] campo1;
  logic [7:0] campo2;
  logic       wr_req;
  logic       wr_ack;

  modport master (
    output dato_e, tipo, s_r, campo0, campo1, campo2, wr_req,
    input  dato_s, wr_ack
  );

  modport slave (
    input  dato_e, tipo, s_r, campo0, campo1, campo2, wr_req,
    output dato_s, wr_ack
  );
endinterface

// File: rtl/editor_campos_rtc.sv
// ---------------------------------------------------------------------------
// editor_campos_rtc
// Edit-mode controller for the RTC setting path. Holds three BCD fields
// (hh/mm/ss or dd/mes/aa), moves a cursor over them, requests +1/-1 from an
// external BCD modifier on up/down pulses, captures the modifier result one
// cycle later and hands the edited fields to the RTC writer on exit.
// Ports:
//   clk                 system clock, rising edge
//   reset               synchronous, active-low
//   en_edit             level: high = edit, low = exit and commit
//   grupo               0 = time fields, 1 = date fields (latched on entry)
//   cargar              pulse: load campo_in0..2 while idle
//   campo_in0..2 [7:0]  BCD values read from the RTC
//   btn_arriba/abajo/izq/der  single-cycle button pulses
//   campo_sel [1:0]     cursor position 0..2
//   editando            high while editing or committing
//   bus                 master side of editor_campos_rtc_if
// ---------------------------------------------------------------------------
module editor_campos_rtc (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_edit,
  input  logic       grupo,
  input  logic       cargar,
  input  logic [7:0] campo_in0,
  input  logic [7:0] campo_in1,
  input  logic [7:0] campo_in2,
  input  logic       btn_arriba,
  input  logic       btn_abajo,
  input  logic       btn_izq,
  input  logic       btn_der,
  output logic [1:0] campo_sel,
  output logic       editando,
  editor_campos_rtc_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EDIT   = 2'd1;
  localparam logic [1:0] MOD    = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  logic [1:0] state_reg, state_next;
  logic [1:0] sel_reg, sel_next;
  logic       s_r_reg, s_r_next;
  logic       grupo_reg;
  logic [7:0] campo0_reg, campo1_reg, campo2_reg;
  logic [7:0] dato_e_mux;
  logic [4:0] tipo_mux;

  // Next-state, cursor and direction decisions.
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    s_r_next   = s_r_reg;
    case (state_reg)
      IDLE: begin
        if (en_edit) begin
          state_next = EDIT;
          sel_next   = 2'd0;
        end
      end
      EDIT: begin
        if (!en_edit) begin
          state_next = COMMIT;
        end else if (btn_arriba ^ btn_abajo) begin
          s_r_next   = btn_arriba;
          state_next = MOD;
        end else if (!btn_arriba && !btn_abajo) begin
          // Up and down together swallow the whole cycle, so cursor moves
          // are only considered when neither is pressed.
          if (btn_der && !btn_izq) begin
            sel_next = (sel_reg == 2'd2) ? 2'd0 : sel_reg + 2'd1;
          end else if (btn_izq && !btn_der) begin
            sel_next = (sel_reg == 2'd0) ? 2'd2 : sel_reg - 2'd1;
          end
        end
      end
      MOD: begin
        // Always return to EDIT so the capture completes; exit is taken there.
        state_next = EDIT;
      end
      COMMIT: begin
        if (bus.wr_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      sel_reg   <= 2'd0;
      s_r_reg   <= 1'b1;
      grupo_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      s_r_reg   <= s_r_next;
      if (state_reg == IDLE && en_edit) begin
        grupo_reg <= grupo;
      end
    end
  end

  // Field registers: loaded from the RTC while idle, written with the
  // modifier result at the end of the single MOD cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      campo0_reg <= 8'h00;
      campo1_reg <= 8'h00;
      campo2_reg <= 8'h00;
    end else if (state_reg == IDLE && cargar) begin
      campo0_reg <= campo_in0;
      campo1_reg <= campo_in1;
      campo2_reg <= campo_in2;
    end else if (state_reg == MOD) begin
      case (sel_reg)
        2'd0:    campo0_reg <= bus.dato_s;
        2'd1:    campo1_reg <= bus.dato_s;
        2'd2:    campo2_reg <= bus.dato_s;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (sel_reg)
      2'd1:    dato_e_mux = campo1_reg;
      2'd2:    dato_e_mux = campo2_reg;
      default: dato_e_mux = campo0_reg;
    endcase
  end

  // Range code for the modifier: 23/59/59 for time, 31/12/99 for date.
  always_comb begin
    case ({grupo_reg, sel_reg})
      3'b001:  tipo_mux = 5'b01000;
      3'b010:  tipo_mux = 5'b01000;
      3'b100:  tipo_mux = 5'b00100;
      3'b101:  tipo_mux = 5'b00001;
      3'b110:  tipo_mux = 5'b10000;
      default: tipo_mux = 5'b00010;
    endcase
  end

  assign bus.dato_e = dato_e_mux;
  assign bus.tipo   = tipo_mux;
  assign bus.s_r    = s_r_reg;
  assign bus.campo0 = campo0_reg;
  assign bus.campo1 = campo1_reg;
  assign bus.campo2 = campo2_reg;
  assign bus.wr_req = (state_reg == COMMIT);
  assign campo_sel  = sel_reg;
  assign editando   = (state_reg != IDLE);

endmodule

// File: tb/tb_editor_campos_rtc.sv
// ---------------------------------------------------------------------------
// tb_editor_campos_rtc
// Directed, table-driven bench for editor_campos_rtc with a behavioural BCD
// modifier closing the dato_e/tipo/s_r -> dato_s loop.
// ---------------------------------------------------------------------------
module tb_editor_campos_rtc;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_edit, grupo, cargar;
  logic [7:0] campo_in0, campo_in1, campo_in2;
  logic       btn_arriba, btn_abajo, btn_izq, btn_der;
  logic [1:0] campo_sel;
  logic       editando;

  editor_campos_rtc_if bus ();

  editor_campos_rtc dut (
    .clk        (clk),
    .reset      (reset),
    .en_edit    (en_edit),
    .grupo      (grupo),
    .cargar     (cargar),
    .campo_in0  (campo_in0),
    .campo_in1  (campo_in1),
    .campo_in2  (campo_in2),
    .btn_arriba (btn_arriba),
    .btn_abajo  (btn_abajo),
    .btn_izq    (btn_izq),
    .btn_der    (btn_der),
    .campo_sel  (campo_sel),
    .editando   (editando),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Behavioural BCD modifier: +1/-1 with wrap inside the range of tipo.
  function automatic logic [7:0] bcd_mod(input logic [7:0] d, input logic [4:0] t, input logic up);
    int v, mx, mn, r;
    v = int'(d[7:4]) * 10 + int'(d[3:0]);
    case (t)
      5'b00010: begin mx = 23; mn = 0; end
      5'b01000: begin mx = 59; mn = 0; end
      5'b00100: begin mx = 31; mn = 1; end
      5'b00001: begin mx = 12; mn = 1; end
      default:  begin mx = 99; mn = 0; end
    endcase
    if (up) r = (v >= mx) ? mn : v + 1;
    else    r = (v <= mn) ? mx : v - 1;
    return 8'(((r / 10) << 4) | (r % 10));
  endfunction

  always_comb bus.dato_s = bcd_mod(bus.dato_e, bus.tipo, bus.s_r);

  typedef struct {
    logic       cg, en, gp, ar, ab, iz, de, wk;
    logic [7:0] ci0, ci1, ci2;
    logic [7:0] c0, c1, c2;
    logic [1:0] sel;
    logic       ed, wr, sr;
    logic [4:0] tipo;
    logic [7:0] dato_e;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic cg, en, gp, ar, ab, iz, de, wk,
                     input logic [7:0] ci0, ci1, ci2, c0, c1, c2,
                     input logic [1:0] sel, input logic ed, wr, sr,
                     input logic [4:0] tipo, input logic [7:0] dato_e);
    vec_t v;
    v.cg = cg; v.en = en; v.gp = gp; v.ar = ar; v.ab = ab; v.iz = iz; v.de = de; v.wk = wk;
    v.ci0 = ci0; v.ci1 = ci1; v.ci2 = ci2;
    v.c0 = c0; v.c1 = c1; v.c2 = c2;
    v.sel = sel; v.ed = ed; v.wr = wr; v.sr = sr; v.tipo = tipo; v.dato_e = dato_e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] c0, c1, c2, input logic [1:0] sel,
                         input logic ed, wr, sr, input logic [4:0] tipo, input logic [7:0] de);
    chk({tag, ".campo0"},    32'(bus.campo0), 32'(c0));
    chk({tag, ".campo1"},    32'(bus.campo1), 32'(c1));
    chk({tag, ".campo2"},    32'(bus.campo2), 32'(c2));
    chk({tag, ".campo_sel"}, 32'(campo_sel),  32'(sel));
    chk({tag, ".editando"},  32'(editando),   32'(ed));
    chk({tag, ".wr_req"},    32'(bus.wr_req), 32'(wr));
    chk({tag, ".s_r"},       32'(bus.s_r),    32'(sr));
    chk({tag, ".tipo"},      32'(bus.tipo),   32'(tipo));
    chk({tag, ".dato_e"},    32'(bus.dato_e), 32'(de));
  endtask

  task automatic drive(input logic cg, en, gp, ar, ab, iz, de, wk,
                       input logic [7:0] ci0, ci1, ci2);
    cargar = cg; en_edit = en; grupo = gp;
    btn_arriba = ar; btn_abajo = ab; btn_izq = iz; btn_der = de;
    bus.wr_ack = wk;
    campo_in0 = ci0; campo_in1 = ci1; campo_in2 = ci2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- vector table ----------------
    // Time group: load 23/45/10, increment hours (23 -> 00), decrement minutes.
    add(1,0,0,0,0,0,0,0, 8'h23,8'h45,8'h10, 8'h23,8'h45,8'h10, 0,0,0,1, 5'b00010, 8'h23);
    add(0,1,0,0,0,0,0,0, 8'h00,8'h00,8'h00, 8'h23,8'h45,8'h10, 0,1,0,1, 5'b00010, 8'h23);
    add(0,1,0,1,0,0,0,0, 8'h00,8'h00,8'h00, 8'h23,8'h45,8'h10, 0,1,0,1, 5'b00010, 8'h23);
    add(0,1,0,0,0,0,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h45,8'h10, 0,1,0,1, 5'b00010, 8'h00);
    add(0,1,0,0,0,0,1,0, 8'h00,8'h00,8'h00, 8'h00,8'h45,8'h10, 1,1,0,1, 5'b01000, 8'h45);
    add(0,1,0,0,1,0,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h45,8'h10, 1,1,0,0, 5'b01000, 8'h45);
    add(0,1,0,1,0,0,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h44,8'h10, 1,1,0,0, 5'b01000, 8'h44);
    // up+down together: no-op
    add(0,1,0,1,1,0,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h44,8'h10, 1,1,0,0, 5'b01000, 8'h44);
    // up on two consecutive cycles: one increment only
    add(0,1,0,1,0,0,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h44,8'h10, 1,1,0,1, 5'b01000, 8'h44);
    add(0,1,0,1,0,0,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h45,8'h10, 1,1,0,1, 5'b01000, 8'h45);
    add(0,1,0,0,0,0,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h45,8'h10, 1,1,0,1, 5'b01000, 8'h45);
    // left+right together: no-op; then cursor wraps both ways
    add(0,1,0,0,0,1,1,0, 8'h00,8'h00,8'h00, 8'h00,8'h45,8'h10, 1,1,0,1, 5'b01000, 8'h45);
    add(0,1,0,0,0,0,1,0, 8'h00,8'h00,8'h00, 8'h00,8'h45,8'h10, 2,1,0,1, 5'b01000, 8'h10);
    add(0,1,0,0,0,0,1,0, 8'h00,8'h00,8'h00, 8'h00,8'h45,8'h10, 0,1,0,1, 5'b00010, 8'h00);
    add(0,1,0,0,0,1,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h45,8'h10, 2,1,0,1, 5'b01000, 8'h10);
    // Commit: wr_ack before COMMIT ignored, cargar/buttons ignored, 5 cycles without ack
    add(1,0,0,0,0,0,0,1, 8'h11,8'h22,8'h33, 8'h00,8'h45,8'h10, 2,1,1,1, 5'b01000, 8'h10);
    for (int i = 0; i < 5; i++)
      add(1,0,0,1,0,0,0,0, 8'h11,8'h22,8'h33, 8'h00,8'h45,8'h10, 2,1,1,1, 5'b01000, 8'h10);
    add(0,0,0,0,0,0,0,1, 8'h00,8'h00,8'h00, 8'h00,8'h45,8'h10, 2,0,0,1, 5'b01000, 8'h10);
    add(0,0,0,0,0,0,0,1, 8'h00,8'h00,8'h00, 8'h00,8'h45,8'h10, 2,0,0,1, 5'b01000, 8'h10);
    // Date group: 01/01/16, month 01 -> 12, year 16 -> 17, exit straight after MOD
    add(1,0,0,0,0,0,0,0, 8'h01,8'h01,8'h16, 8'h01,8'h01,8'h16, 2,0,0,1, 5'b01000, 8'h16);
    add(0,1,1,0,0,0,0,0, 8'h00,8'h00,8'h00, 8'h01,8'h01,8'h16, 0,1,0,1, 5'b00100, 8'h01);
    add(0,1,0,0,0,0,1,0, 8'h00,8'h00,8'h00, 8'h01,8'h01,8'h16, 1,1,0,1, 5'b00001, 8'h01);
    add(0,1,0,0,1,0,0,0, 8'h00,8'h00,8'h00, 8'h01,8'h01,8'h16, 1,1,0,0, 5'b00001, 8'h01);
    add(0,1,0,0,0,0,0,0, 8'h00,8'h00,8'h00, 8'h01,8'h12,8'h16, 1,1,0,0, 5'b00001, 8'h12);
    add(0,1,0,0,0,1,0,0, 8'h00,8'h00,8'h00, 8'h01,8'h12,8'h16, 0,1,0,0, 5'b00100, 8'h01);
    add(0,1,0,0,0,1,0,0, 8'h00,8'h00,8'h00, 8'h01,8'h12,8'h16, 2,1,0,0, 5'b10000, 8'h16);
    add(0,1,0,1,0,0,0,0, 8'h00,8'h00,8'h00, 8'h01,8'h12,8'h16, 2,1,0,1, 5'b10000, 8'h16);
    add(0,0,0,0,0,0,0,0, 8'h00,8'h00,8'h00, 8'h01,8'h12,8'h17, 2,1,0,1, 5'b10000, 8'h17);
    add(0,0,0,0,0,0,0,0, 8'h00,8'h00,8'h00, 8'h01,8'h12,8'h17, 2,1,1,1, 5'b10000, 8'h17);
    add(0,0,0,0,0,0,0,1, 8'h00,8'h00,8'h00, 8'h01,8'h12,8'h17, 2,0,0,1, 5'b10000, 8'h17);

    // ---------------- reset with random inputs ----------------
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom));
      step();
    end
    chk_all("reset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 5'b00010, 8'h00);
    $display("reset: campo=%h/%h/%h sel=%0d editando=%0b wr_req=%0b",
             bus.campo0, bus.campo1, bus.campo2, campo_sel, editando, bus.wr_req);
    drive(0,0,0,0,0,0,0,0, 8'h00,8'h00,8'h00);
    reset = 1'b1;
    step();
    chk_all("idle", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 5'b00010, 8'h00);

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      drive(vecs[i].cg, vecs[i].en, vecs[i].gp, vecs[i].ar, vecs[i].ab, vecs[i].iz,
            vecs[i].de, vecs[i].wk, vecs[i].ci0, vecs[i].ci1, vecs[i].ci2);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].sel,
              vecs[i].ed, vecs[i].wr, vecs[i].sr, vecs[i].tipo, vecs[i].dato_e);
      $display("vec %0d: campo=%h/%h/%h sel=%0d editando=%0b wr_req=%0b s_r=%0b tipo=%b dato_e=%h",
               i, bus.campo0, bus.campo1, bus.campo2, campo_sel, editando, bus.wr_req,
               bus.s_r, bus.tipo, bus.dato_e);
    end

    // ---------------- reset while in MOD ----------------
    drive(1,0,0,0,0,0,0,0, 8'h05,8'h06,8'h07); step();
    drive(0,1,0,0,0,0,0,0, 8'h00,8'h00,8'h00); step();
    chk("mod_rst.enter_edit", 32'(editando), 32'd1);
    drive(0,1,0,1,0,0,0,0, 8'h00,8'h00,8'h00); step();
    chk("mod_rst.dato_e_in_mod", 32'(bus.dato_e), 32'h05);
    reset = 1'b0;
    drive(0,1,0,0,0,0,0,0, 8'h00,8'h00,8'h00); step();
    chk_all("mod_rst", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 5'b00010, 8'h00);
    reset = 1'b1;
    drive(0,0,0,0,0,0,0,0, 8'h00,8'h00,8'h00); step();
    chk("mod_rst.idle_after", 32'(editando), 32'd0);
    $display("reset in MOD: campo0=%h editando=%0b", bus.campo0, editando);

    // ---------------- reset while in COMMIT ----------------
    drive(0,1,0,0,0,0,0,0, 8'h00,8'h00,8'h00); step();
    drive(0,0,0,0,0,0,0,0, 8'h00,8'h00,8'h00); step();
    chk("commit_rst.wr_req_up", 32'(bus.wr_req), 32'd1);
    reset = 1'b0; step();
    chk("commit_rst.wr_req", 32'(bus.wr_req), 32'd0);
    chk("commit_rst.editando", 32'(editando), 32'd0);
    reset = 1'b1;
    drive(0,0,0,0,0,0,0,1, 8'h00,8'h00,8'h00); step();
    chk("commit_rst.idle_wr_req", 32'(bus.wr_req), 32'd0);
    chk("commit_rst.idle_editando", 32'(editando), 32'd0);
    $display("reset in COMMIT: wr_req=%0b editando=%0b", bus.wr_req, editando);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/editor_campos_rtc.md
# editor_campos_rtc

Edit-mode controller for the RTC setting path. It holds three BCD fields (hours/minutes/seconds or day/month/year), moves a cursor between them, and on up/down button pulses drives the downstream BCD add/subtract modifier (MODIF_DATOS). It captures the modified value one cycle later and, on leaving edit mode, hands the edited fields to the RTC write sequencer through a request/acknowledge handshake.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- en_edit  in  1  level; high requests edit mode, low requests exit/commit.
- grupo  in  1  0 = time fields (hh, mm, ss); 1 = date fields (dd, mes, aa); latched on entry to EDIT.
- cargar  in  1  pulse; in IDLE loads campo_in0..2 into field registers.
- campo_in0, campo_in1, campo_in2  in  8 each  BCD values read from the RTC.
- btn_arriba, btn_abajo, btn_izq, btn_der  in  1 each  debounced single-cycle pulses.
- dato_s  in  8  BCD result returned by the modifier.
- wr_ack  in  1  write sequencer acknowledge.
- dato_e  out  8  BCD value of the selected field, to the modifier.
- tipo  out  5  one-hot range code for the selected field, to the modifier.
- s_r  out  1  1 = add one, 0 = subtract one; to the modifier.
- campo0, campo1, campo2  out  8 each  current BCD field values, to display/RTC.
- campo_sel  out  2  cursor position, 0..2.
- editando  out  1  high in EDIT, MOD and COMMIT.
- wr_req  out  1  commit request to the write sequencer.

## Operation
- States: IDLE, EDIT, MOD, COMMIT.
- IDLE:
  - A cargar pulse copies campo_in0..2 to campo0..2.
  - en_edit high moves to EDIT next cycle, latches grupo and sets campo_sel = 0.
- EDIT: one action per cycle, evaluated in this priority:
  1. en_edit low → COMMIT.
  2. Exactly one of btn_arriba/btn_abajo set → set s_r (arriba = 1, abajo = 0), go to MOD.
  3. btn_arriba and btn_abajo together → no-op.
  4. btn_der → campo_sel + 1, wrapping 2 → 0.
  5. btn_izq → campo_sel − 1, wrapping 0 → 2.
  6. btn_der and btn_izq together → no-op.
- MOD: lasts exactly one cycle. At the closing edge, dato_s is written into the field at campo_sel. The next state is EDIT, even if en_edit has dropped; the exit is then taken from EDIT.
- COMMIT: wr_req is held high until wr_ack is sampled high, then the block goes to IDLE. Field values are frozen while in COMMIT.
- tipo mapping:
  - grupo 0: field 0 → 00010 (max 23), field 1 → 01000 (59), field 2 → 01000 (59).
  - grupo 1: field 0 → 00100 (31), field 1 → 00001 (12), field 2 → 10000 (99).
- dato_e = selected field register (combinational mux).
- Range wrap and BCD arithmetic belong to the modifier; this block never alters dato_s.
- Button pulses are ignored in IDLE, MOD and COMMIT. cargar is ignored outside IDLE.

## Timing
- Reset values:
  - State IDLE.
  - campo0..2 = 8'h00, campo_sel = 0, latched grupo = 0.
  - s_r = 1, tipo = 5'b00010, dato_e = 8'h00.
  - editando = 0, wr_req = 0.
- Reset applied in any state, including MOD or COMMIT with wr_req high, returns to the reset values at the next edge. No pending capture or commit survives.
- en_edit sampled high in IDLE at edge N: editando = 1 after edge N.
- Button pulse in EDIT at edge N: s_r, dato_e and tipo are stable from edge N through edge N+1. The field is updated after edge N+1. EDIT is re-entered after edge N+1.
- Minimum spacing of two effective increments is 2 cycles; a pulse arriving during MOD is dropped.
- Cursor move takes effect after the sampling edge; tipo and dato_e follow combinationally.
- wr_req rises one cycle after en_edit is sampled low in EDIT. It falls on the edge where wr_ack is sampled high, and the block is in IDLE on that same edge.
- wr_ack high outside COMMIT is ignored.

## Test plan
- Reset: hold reset = 0 for 3 cycles with random inputs → all outputs at reset values; state IDLE.
- Load and increment: cargar with campo_in = 23/45/10 (BCD), en_edit = 1, btn_arriba once → dato_e = 8'h23, tipo = 00010, s_r = 1 during MOD; campo0 = 8'h00 two cycles after the pulse (modifier model wraps 23 → 00).
- Cursor and decrement in date group: grupo = 1, fields 01/01/16, btn_der, then btn_abajo → campo_sel = 1, tipo = 00001; campo1 = 8'h12. Then btn_izq twice → campo_sel = 2.
- Conflicts: btn_arriba and btn_abajo together → no field change, state stays EDIT. btn_arriba pulsed on consecutive cycles → exactly one increment.
- Commit handshake: drop en_edit, hold wr_ack low for 5 cycles, then high → wr_req high for those cycles; fields frozen; IDLE and wr_req = 0 after the ack edge.
- Reset mid-operation: assert reset in MOD and in COMMIT → field not updated, wr_req = 0, IDLE next edge.
